// File: rtl/line_trail_renderer.sv
// Trail hit-test for the pixel path: live ring of turn points, frame-start shadow
// snapshot, and a 2-stage pipeline producing body/head hit flags per scanned pixel.
module line_trail_renderer #(
   parameter int DEPTH   = 16,
   parameter int COORD_W = 16,
   parameter int HALF    = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     turn,
   input  logic                     frame_start,
   input  logic [COORD_W-1:0]       head_x,
   input  logic [COORD_W-1:0]       head_y,
   input  logic [COORD_W-1:0]       scroll_x,
   input  logic [COORD_W-1:0]       scroll_y,
   input  logic [9:0]               h_cnt,
   input  logic [9:0]               v_cnt,
   input  logic                     valid,
   output logic                     pix_valid,
   output logic                     body_hit,
   output logic                     head_hit,
   output logic [$clog2(DEPTH):0]   seg_count,
   output logic                     wrapped
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef logic [COORD_W-1:0] coord_t;

   localparam coord_t HALF_C = coord_t'(HALF);
   localparam coord_t MAX_C  = '1;

   coord_t             live_x [DEPTH];
   coord_t             live_y [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;

   coord_t             sh_x [DEPTH];
   coord_t             sh_y [DEPTH];
   logic [PTR_W-1:0]   sh_ptr;
   logic [CNT_W-1:0]   sh_count;
   coord_t             sh_hx;
   coord_t             sh_hy;
   // Nothing renders after reset until a frame_start has loaded real geometry.
   logic               sh_armed;

   coord_t             s1_wx;
   coord_t             s1_wy;
   logic               s1_valid;

   logic               body_c;
   logic               head_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            live_x[i] <= '0;
            live_y[i] <= '0;
         end
         wr_ptr  <= '0;
         count   <= '0;
         wrapped <= 1'b0;
      end else if (clear) begin
         wr_ptr  <= '0;
         count   <= '0;
         wrapped <= 1'b0;
      end else if (turn) begin
         live_x[wr_ptr] <= head_x;
         live_y[wr_ptr] <= head_y;
         wr_ptr         <= wr_ptr + 1'b1;
         if (count == CNT_W'(DEPTH)) begin
            wrapped <= 1'b1;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   // Non-blocking reads give the pre-turn/pre-clear live state to the shadow.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            sh_x[i] <= '0;
            sh_y[i] <= '0;
         end
         sh_ptr   <= '0;
         sh_count <= '0;
         sh_hx    <= '0;
         sh_hy    <= '0;
         sh_armed <= 1'b0;
      end else if (frame_start) begin
         for (int i = 0; i < DEPTH; i++) begin
            sh_x[i] <= live_x[i];
            sh_y[i] <= live_y[i];
         end
         sh_ptr   <= wr_ptr;
         sh_count <= count;
         sh_hx    <= head_x;
         sh_hy    <= head_y;
         sh_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_wx    <= '0;
         s1_wy    <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_wx    <= coord_t'(h_cnt) + scroll_x;
         s1_wy    <= coord_t'(v_cnt) + scroll_y;
         s1_valid <= valid;
      end
   end

   function automatic logic in_span(coord_t a, coord_t b, coord_t w);
      coord_t mn, mx, lo, hi;
      mn = (a < b) ? a : b;
      mx = (a < b) ? b : a;
      lo = (mn < HALF_C) ? '0 : mn - HALF_C;
      hi = (mx > MAX_C - HALF_C) ? MAX_C : mx + HALF_C;
      return (w >= lo) && (w <= hi);
   endfunction

   // Segment k joins P(k-1) (or the head for k=0) to Pk, Pk = sh[sh_ptr-1-k].
   always_comb begin
      logic [PTR_W-1:0] idx;
      logic [PTR_W-1:0] pidx;
      coord_t           xa, ya;
      body_c = 1'b0;
      head_c = in_span(sh_hx, sh_hx, s1_wx) && in_span(sh_hy, sh_hy, s1_wy);
      idx    = '0;
      pidx   = '0;
      xa     = '0;
      ya     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx  = sh_ptr - PTR_W'(k + 1);
         pidx = idx + 1'b1;
         xa   = (k == 0) ? sh_hx : sh_x[pidx];
         ya   = (k == 0) ? sh_hy : sh_y[pidx];
         if ((CNT_W'(k) < sh_count) &&
             in_span(xa, sh_x[idx], s1_wx) && in_span(ya, sh_y[idx], s1_wy)) begin
            body_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pix_valid <= 1'b0;
         body_hit  <= 1'b0;
         head_hit  <= 1'b0;
      end else begin
         pix_valid <= s1_valid;
         body_hit  <= s1_valid & sh_armed & body_c;
         head_hit  <= s1_valid & sh_armed & head_c;
      end
   end

   assign seg_count = count;

endmodule
